// File: rtl/decoder_arb_pkg.sv
// Shared types and helpers for the decoder-based round-robin arbiter.
// Holds the FSM state type, sizing constants and the rotating-priority pick.
package decoder_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // First set bit scanning ptr, ptr+1, ... (mod NUM_REQ)
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    win = ptr;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_dec2to4.sv
// 2-to-4 one-hot decoder with enable.
// Its outputs are the arbiter's grant lines.
module arb_grant_dec2to4
  import decoder_arb_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [3:0]       y
);

  always_comb begin
    y = 4'b0000;
    unique case (1'b1)
      (en && idx == 2'd0): y = 4'b0001;
      (en && idx == 2'd1): y = 4'b0010;
      (en && idx == 2'd2): y = 4'b0100;
      (en && idx == 2'd3): y = 4'b1000;
      default:             y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter driving a shared 2-to-4 decoder.
// A hold-limit timer force-releases grants held for MAX_HOLD cycles.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  output logic [3:0]   gnt,
  output logic [1:0]   gnt_idx,
  output logic         gnt_valid,
  output logic         timeout,
  output logic         busy
);

  localparam bit LIMIT = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(LIMIT ? MAX_HOLD - 1 : 0);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  logic rel_norm;
  logic rel_force;

  assign rel_norm  = !req[gnt_idx_q];
  assign rel_force = LIMIT && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_idx_d   = next_rr(req, ptr_q);
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // A voluntary drop wins over the timer in the same cycle
        if (rel_norm || rel_force) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          state_d     = IDLE;
          timeout_d   = !rel_norm;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  arb_grant_dec2to4 u_dec (
    .en  (gnt_valid_q),
    .idx (gnt_idx_q),
    .y   (gnt)
  );

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign busy      = gnt_valid_q;

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Four-requester round-robin arbiter that shares a single 2-to-4 decoder between four requesters.
- The arbiter holds a registered 2-bit grant index and a grant-valid bit. These drive the decoder's address and enable inputs, so the decoder's one-hot outputs are the grant lines.
- Sits between requesting agents and a shared resource selected one-hot.
- Adds a hold-limit timer so that no requester can monopolise the resource.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles per grant. 0 = unlimited. Legal range 0..255.
- HOLD_W, 8: width of the hold counter. Must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request vector; req[i] high = requester i wants the resource.
- gnt  output  4  one-hot grant. Decoded output: gnt[i] = gnt_valid & (gnt_idx == i).
- gnt_idx  output  2  registered index of the current or last grantee.
- gnt_valid  output  1  registered; high while a grant is active (decoder enable).
- timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.
- busy  output  1  equals gnt_valid.

Behaviour:
- Reset (rst_n low, takes effect immediately and asynchronously):
  - state = IDLE, gnt_valid = 0, gnt_idx = 2'd0, ptr = 2'd0, hold_cnt = 0, timeout = 0.
  - gnt = 4'b0000 immediately.
  - Reset mid-grant drops the grant in the same instant; no release bookkeeping is done.
- State machine, two states: IDLE and GRANT.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: gnt_idx = winner, gnt_valid = 1, hold_cnt = 0, go to GRANT.
  - Latency is exactly one cycle from req sampled high in IDLE to gnt high.
- GRANT:
  - Normal release: req[gnt_idx] sampled low. Next edge: gnt_valid = 0, ptr = gnt_idx + 1 (mod 4, 3 wraps to 0), go to IDLE, timeout stays 0.
  - Forced release: MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 while req[gnt_idx] is still high. Next edge: same as normal release, plus timeout = 1 for exactly one cycle.
  - If both release conditions are true in the same cycle, treat it as a normal release (timeout = 0).
  - Otherwise hold_cnt increments (saturating at all-ones when MAX_HOLD = 0); gnt_idx and gnt_valid are unchanged.
  - Requests from other requesters have no effect during GRANT; there is no preemption other than the timeout.
- Every grant is followed by at least one IDLE cycle with gnt = 0. This makes the resource handover break-before-make.
- gnt_idx retains its last value while in IDLE; only gnt_valid clears.
- A requester that is force-released and keeps req high becomes lowest priority. It is re-granted only after every other active requester has been served.
- MAX_HOLD = 1: every grant lasts exactly 1 cycle, and timeout pulses whenever req is still held.
- Invariants: gnt is always one-hot or zero; gnt != 0 only when state == GRANT.

Decomposition:
- Shared package decoder_arb_pkg holds:
  - state typedef (enum logic {IDLE, GRANT});
  - NUM_REQ = 4 and IDX_W = 2 constants;
  - a function next_rr(req, ptr) returning the winner index.
- One sub-module, arb_grant_dec2to4: purely combinational decoder with enable, inputs en and idx[1:0], output y[3:0] with y[i] = en & (idx == i). It is instantiated once to produce gnt.
- FSM, pointer and hold counter live in the top module.

Test Plan:
- Reset: rst_n = 0 with req = 4'b1111 -> gnt = 0000, gnt_valid = 0, timeout = 0. Release reset; one cycle after the first edge gnt = 0001.
- Rotation: req = 4'b1111 held, each grantee drops req one cycle after its grant, MAX_HOLD = 8 -> grant order 0,1,2,3,0 with a zero cycle between grants.
- Pointer wrap: grant 3, release, then req = 4'b0101 -> next grant is requester 0 (gnt = 0001), not 2.
- Timeout: MAX_HOLD = 4, req = 4'b0011 held high -> gnt = 0001 for exactly 4 cycles, timeout pulses 1 cycle, one idle cycle, then gnt = 0010.
- Simultaneous release: MAX_HOLD = 4, grantee drops req exactly on the 4th granted cycle -> release with timeout = 0.
- Async reset mid-grant: assert rst_n low between edges while gnt = 0100 -> gnt = 0000 immediately. After release with req = 4'b0100, the next grant is 0100 with ptr back at 0.
